instr_encode_loader: RTL and testbench
======================================

Name: instr_encode_loader

Overview:
Encodes structured instruction fields into 32-bit RV32I words for the four classes the main decoder handles: R-type, load, store and branch. It writes the words sequentially into instruction memory through a single write port. It is the producer end of the opcode/immediate interface that the main decoder consumes, and serves as the on-chip program loader for bring-up and self-test. Input uses a valid/ready stream; output writes are registered.

Parameters:
ADDR_W, 10, instruction-memory word-address width; capacity = 2**ADDR_W words.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
restart  input  1  synchronous pulse; rewind write pointer, clear full/err
in_valid  input  1  instruction fields valid
in_ready  output  1  block can accept fields this cycle
cls  input  2  0=R (op 0110011), 1=load (0000011), 2=store (0100011), 3=branch (1100011)
rd  input  5  destination register (R, load)
rs1  input  5  source register 1
rs2  input  5  source register 2 (R, store, branch)
funct3  input  3  funct3 field
funct7b5  input  1  R-type funct7 bit 5 (sub/sra)
imm  input  13  signed immediate; bit 12 is the sign
mem_we  output  1  one-cycle write strobe
mem_addr  output  ADDR_W  word address of write
mem_wdata  output  32  encoded instruction
count  output  ADDR_W+1  words written since reset/restart
full  output  1  memory filled; no further accepts
err  output  1  sticky: an illegal beat was dropped

Behaviour:
- Reset (async, rst_n=0): mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, err=0, write pointer=0. Any pending write is discarded. Outputs are held while rst_n=0.
- in_ready = ~full & ~restart & rst_n-deasserted. A beat is accepted when in_valid & in_ready are both high at a clk edge.
- Latency: an accepted legal beat produces mem_we=1, mem_addr=ptr, mem_wdata=encoded word in the cycle after acceptance, for exactly one cycle. ptr and count increment on that same edge. Back-to-back accepts produce back-to-back writes, one per cycle.
- Encoding (bit positions of the standard RV32I formats):
  - R: {1'b0, funct7b5, 5'b0, rs2, rs1, funct3, rd, 0110011}; imm is ignored.
  - Load (I): {imm[11:0], rs1, funct3, rd, 0000011}; rs2 is ignored.
  - Store (S): {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}; rd is ignored.
  - Branch (B): {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}; rd is ignored.
- Legality:
  - Load/store require imm[12]==imm[11] (range -2048..2047).
  - Branch requires imm[0]==0.
  - An illegal beat is still accepted (consumed), but no write occurs, ptr and count are unchanged, and err is set. err stays set until restart or reset.
- State machine, two states:
  - LOAD: accepting beats.
  - FULL: entered on the edge that issues the write to address 2**ADDR_W-1. In FULL, full=1, in_ready=0, and no writes occur. Leave only via restart or reset.
- Wrap-around: ptr never wraps silently; the FULL state prevents overflow. count saturates at 2**ADDR_W.
- restart:
  - Next edge: ptr=0, count=0, full=0, err=0, state=LOAD.
  - A write already registered in the restart cycle completes normally at its latched address.
  - in_valid in the restart cycle is not accepted, because in_ready=0.
- mem_wdata and mem_addr hold their last values when mem_we=0.

Decomposition:
- Shared package/header: class codes (CLS_R/LOAD/STORE/BRANCH), opcode constants (OP_R=0110011, OP_LOAD=0000011, OP_STORE=0100011, OP_BRANCH=1100011) and state encodings. The same opcode constants are used by the main decoder.
- One natural combinational sub-module, instr_format_enc: maps {cls, fields, imm} to {word, illegal}. The top holds the handshake, pointer/count, FSM and output registers.

Test Plan:
- R-type: cls=0, rd=3, rs1=1, rs2=2, funct3=0, funct7b5=0 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x002081B3. Repeat with funct7b5=1 -> 0x402081B3 at addr 1, count=2.
- Load/store: lw x5,8(x2) (imm=8, funct3=2) -> 0x00812283. sw x5,-4(x2) (imm=0x1FFC) -> 0xFE512E23. Both are back-to-back accepts giving writes on consecutive cycles at consecutive addresses.
- Branch: beq x1,x2,-8 (imm=0x1FF8, funct3=0) -> 0xFE208CE3.
- Illegal: branch imm=5, then load imm=0x0800 -> no mem_we, count unchanged, err=1 and sticky. A following legal beat writes at the unchanged pointer. restart clears err.
- Full, with ADDR_W=2: 4 legal beats -> writes at addr 0..3, full=1, in_ready=0, and a 5th in_valid is ignored. restart -> full=0, count=0, and the next beat writes addr 0.
- Reset mid-operation: drop rst_n in the cycle after an accept -> no mem_we, all outputs 0 asynchronously. After release, the first beat writes addr 0.

Source files
------------

// File: rtl/instr_encode_loader_pkg.sv
// Shared constants and types for the RV32I instruction encoder/loader.
package instr_encode_loader_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned REG_W = 5;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned IMM_W = 13;

  // Instruction classes handled by the main decoder
  typedef enum logic [1:0] {
    CLS_R      = 2'd0,
    CLS_LOAD   = 2'd1,
    CLS_STORE  = 2'd2,
    CLS_BRANCH = 2'd3
  } cls_e;

  // Major opcodes, shared with the main decoder
  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;

  // Loader state machine
  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_FULL = 1'b1
  } state_e;

  // Instruction field bundle presented to the encoder
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [F3_W-1:0]  funct3;
    logic             funct7b5;
    logic [IMM_W-1:0] imm;
  } instr_fields_t;

  // A 13-bit immediate fits a 12-bit signed field when its top two bits agree
  function automatic logic imm_fits12(input logic [IMM_W-1:0] imm);
    return imm[12] == imm[11];
  endfunction

endpackage

// File: rtl/instr_encode_loader_format_enc.sv
// Combinational RV32I format encoder: fields + class -> word, illegal flag.
module instr_format_enc
  import instr_encode_loader_pkg::*;
(
  input  logic [1:0]      cls,
  input  instr_fields_t   fields,
  output logic [XLEN-1:0] word,
  output logic            illegal
);

  // Place fields at standard R/I/S/B bit positions and flag unencodable immediates
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (cls_e'(cls))
      CLS_R: begin
        word = {1'b0, fields.funct7b5, 5'b0, fields.rs2, fields.rs1,
                fields.funct3, fields.rd, OP_R};
      end
      CLS_LOAD: begin
        word    = {fields.imm[11:0], fields.rs1, fields.funct3, fields.rd, OP_LOAD};
        illegal = ~imm_fits12(fields.imm);
      end
      CLS_STORE: begin
        word    = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                   fields.imm[4:0], OP_STORE};
        illegal = ~imm_fits12(fields.imm);
      end
      CLS_BRANCH: begin
        word    = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1,
                   fields.funct3, fields.imm[4:1], fields.imm[11], OP_BRANCH};
        illegal = fields.imm[0];
      end
      default: begin
        word    = '0;
        illegal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/instr_encode_loader.sv
// Program loader: encodes instruction beats and writes them sequentially
// into instruction memory, stopping when the memory is full.
module instr_encode_loader
  import instr_encode_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        cls,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic [12:0]       imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e          state;
  state_e          state_next;
  logic [ADDR_W-1:0] ptr;
  instr_fields_t   fields;
  logic [XLEN-1:0] enc_word;
  logic            enc_illegal;
  logic            accept_c;
  logic            wr_c;
  logic            drop_c;

  assign fields = {rd, rs1, rs2, funct3, funct7b5, imm};

  instr_format_enc u_enc (
    .cls     (cls),
    .fields  (fields),
    .word    (enc_word),
    .illegal (enc_illegal)
  );

  assign full     = (state == ST_FULL);
  assign in_ready = (state == ST_LOAD) & ~restart & rst_n;

  // Next-state and beat classification: accept, write or drop
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    wr_c       = 1'b0;
    drop_c     = 1'b0;
    case (state)
      ST_LOAD: begin
        accept_c = in_valid & in_ready;
        wr_c     = accept_c & ~enc_illegal;
        drop_c   = accept_c & enc_illegal;
        if (restart) begin
          state_next = ST_LOAD;
        end else if (wr_c && (ptr == LAST_ADDR)) begin
          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        if (restart) begin
          state_next = ST_LOAD;
        end
      end
      default: begin
        state_next = ST_LOAD;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Write port, pointer, count and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ptr       <= '0;
      count     <= '0;
      err       <= 1'b0;
    end else begin
      mem_we <= wr_c;
      if (wr_c) begin
        mem_addr  <= ptr;
        mem_wdata <= enc_word;
      end
      if (restart) begin
        ptr   <= '0;
        count <= '0;
        err   <= 1'b0;
      end else begin
        if (wr_c) begin
          ptr   <= ptr + ADDR_W'(1);
          count <= count + CNT_W'(1);
        end
        if (drop_c) begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Scoreboard bench for instr_encode_loader with a small memory (4 words).
module tb_instr_encode_loader;

  localparam int unsigned AW  = 2;
  localparam int          CAP = 4;

  logic          clk;
  logic          rst_n;
  logic          restart;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    cls;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [2:0]    funct3;
  logic          funct7b5;
  logic [12:0]   imm;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [AW:0]   count;
  logic          full;
  logic          err;

  instr_encode_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready),
    .cls(cls), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7b5(funct7b5), .imm(imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          addr;
    int unsigned data;
  } wr_t;

  wr_t         exp_q[$];
  int          total = 0;
  int          bad   = 0;

  // reference state
  int          m_ptr;
  int          m_count;
  bit          m_full;
  bit          m_err;
  bit          m_we;
  int          m_last_addr;
  int unsigned m_last_data;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_count = 0; m_full = 0; m_err = 0; m_we = 0;
    m_last_addr = 0; m_last_data = 0;
    exp_q.delete();
  endtask

  // Reference encoder working from the signed immediate value
  function automatic int unsigned ref_enc(input int c, input int d, input int s1,
                                          input int s2, input int f3, input int f7,
                                          input int imm13, output bit legal);
    int          sv;
    int unsigned u;
    int unsigned w;
    sv = (imm13 >= 4096) ? imm13 - 8192 : imm13;
    u  = int'(imm13) & 32'h1FFF;
    legal = 1;
    w = 0;
    case (c)
      0: w = 32'h33 | (d << 7) | (f3 << 12) | (s1 << 15) | (s2 << 20) | (f7 << 30);
      1: begin
        legal = (sv >= -2048) && (sv <= 2047);
        w = 32'h03 | (d << 7) | (f3 << 12) | (s1 << 15) | ((u & 4095) << 20);
      end
      2: begin
        legal = (sv >= -2048) && (sv <= 2047);
        w = 32'h23 | ((u & 31) << 7) | (f3 << 12) | (s1 << 15) | (s2 << 20)
            | (((u >> 5) & 127) << 25);
      end
      default: begin
        legal = (sv % 2) == 0;
        w = 32'h63 | (((u >> 11) & 1) << 7) | (((u >> 1) & 15) << 8) | (f3 << 12)
            | (s1 << 15) | (s2 << 20) | (((u >> 5) & 63) << 25) | (((u >> 12) & 1) << 31);
      end
    endcase
    return w;
  endfunction

  // One clock of stimulus; the model advances on the same edge as the DUT
  task automatic step(input bit v, input bit rs, input int c, input int d, input int s1,
                      input int s2, input int f3, input int f7, input int imm13);
    bit          legal;
    int unsigned w;
    wr_t         e;
    in_valid = v; restart = rs;
    cls = 2'(c); rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2);
    funct3 = 3'(f3); funct7b5 = 1'(f7); imm = 13'(imm13);
    @(posedge clk);
    m_we = 0;
    if (rs) begin
      m_ptr = 0; m_count = 0; m_full = 0; m_err = 0;
    end else if (v && !m_full) begin
      w = ref_enc(c, d, s1, s2, f3, f7, imm13, legal);
      if (legal) begin
        e.addr = m_ptr; e.data = w;
        exp_q.push_back(e);
        m_we = 1;
        m_ptr++; m_count++;
        if (m_ptr == CAP) m_full = 1;
      end else begin
        m_err = 1;
      end
    end
    #1;
    in_valid = 1'b0; restart = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_restart();
    step(1, 1, 0, 1, 1, 1, 0, 0, 0);
  endtask

  // Asynchronous reset applied mid-cycle, outputs checked immediately
  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compares every active cycle against the model and the queue
  always @(negedge clk) begin
    if (rst_n) begin
      check("mem_we", mem_we, m_we);
      if (mem_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("mem_addr", mem_addr, e.addr);
          check("mem_wdata", mem_wdata, e.data);
          m_last_addr = e.addr;
          m_last_data = e.data;
        end
      end else begin
        check("hold_addr", mem_addr, m_last_addr);
        check("hold_wdata", mem_wdata, m_last_data);
      end
      check("count", count, m_count);
      check("full", full, m_full);
      check("err", err, m_err);
      check("in_ready", in_ready, (!m_full && !restart) ? 1 : 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; restart = 1'b0; in_valid = 1'b0;
    cls = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7b5 = 1'b0; imm = '0;
    model_reset();
    #2;
    async_reset();

    // R-type add / sub back to back
    step(1, 0, 0, 3, 1, 2, 0, 0, 0);
    step(1, 0, 0, 3, 1, 2, 0, 1, 0);
    idle(1);
    // lw x5,8(x2) then sw x5,-4(x2): fills addr 2,3 and the memory
    step(1, 0, 1, 5, 2, 0, 2, 0, 8);
    step(1, 0, 2, 0, 2, 5, 2, 0, 'h1FFC);
    // fifth beat while full is ignored
    step(1, 0, 0, 7, 7, 7, 0, 0, 0);
    idle(1);
    do_restart();
    // beq x1,x2,-8 at addr 0
    step(1, 0, 3, 0, 1, 2, 0, 0, 'h1FF8);
    // illegal branch (odd) and illegal load (out of range)
    step(1, 0, 3, 0, 1, 2, 0, 0, 5);
    step(1, 0, 1, 4, 1, 0, 2, 0, 'h0800);
    idle(2);
    // legal beat writes at the unchanged pointer
    step(1, 0, 0, 9, 8, 7, 5, 0, 0);
    idle(1);
    do_restart();
    idle(1);
    // reset in the cycle after an accept
    step(1, 0, 0, 1, 2, 3, 4, 0, 0);
    async_reset();
    step(1, 0, 2, 0, 3, 4, 1, 0, 12);
    idle(1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int c, sv, imm13;
      bit v, rs;
      rs = ($urandom_range(0, 19) == 0);
      v  = ($urandom_range(0, 3) != 0);
      c  = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) begin
        imm13 = int'($urandom_range(0, 8191));
      end else begin
        sv    = (int'($urandom_range(0, 4095)) - 2048) & ~1;
        imm13 = sv & 'h1FFF;
      end
      step(v, rs, c, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 1)), imm13);
    end

    idle(3);
    check("queue_drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
